// File: rtl/data_expander.sv
// data_expander: collects BEATS bus beats into an assembly buffer, slices
// the packed stream into DATA_COUNT elements of ELEM_WIDTH bits, widens
// each to OUT_WIDTH (zero or sign extension), and presents the group in an
// output register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid/data stable until the transfer. The
// consumer may change ready at any time. out_data/out_valid stay stable
// while out_valid && !out_ready.
module data_expander #(
    parameter int BUS_WIDTH  = 64,
    parameter int ELEM_WIDTH = 39,
    parameter int OUT_WIDTH  = 64,
    parameter int DATA_COUNT = 8,
    parameter int SIGN_EXT   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BUS_WIDTH-1:0]            in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_COUNT*OUT_WIDTH-1:0] out_data,
    output logic                            err_last
);

    localparam int PACKED_W = DATA_COUNT * ELEM_WIDTH;
    localparam int BEATS    = (PACKED_W + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int FULL_W   = BEATS * BUS_WIDTH;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]                beat_cnt;
    logic                            accept;
    logic                            final_beat;
    logic                            early_last;
    logic [FULL_W-1:0]               assembled;
    logic [DATA_COUNT*OUT_WIDTH-1:0] lanes;

    // The only stall: the final beat would overwrite a group nobody took yet.
    assign in_ready   = !((beat_cnt == LAST_BEAT) && out_valid && !out_ready);
    assign accept     = in_valid && in_ready;
    assign final_beat = accept && (beat_cnt == LAST_BEAT);
    assign early_last = accept && in_last && (beat_cnt != LAST_BEAT);

    // The final beat is never stored; it is merged straight from in_data so
    // the group is restored in the same cycle it completes.
    generate
        if (BEATS > 1) begin : g_buf
            logic [(BEATS-1)*BUS_WIDTH-1:0] asm_buf;

            // Store each non-final beat in its slot of the assembly buffer.
            always_ff @(posedge clk) begin
                if (accept) begin
                    for (int k = 0; k < BEATS - 1; k++) begin
                        if (beat_cnt == CNT_W'(k)) begin
                            asm_buf[k*BUS_WIDTH +: BUS_WIDTH] <= in_data;
                        end
                    end
                end
            end

            assign assembled = {in_data, asm_buf};
        end else begin : g_nobuf
            assign assembled = in_data;
        end

        // Padding bits of the last beat carry no element data.
        if (FULL_W > PACKED_W) begin : g_tail
            logic unused_tail;
            assign unused_tail = ^assembled[FULL_W-1:PACKED_W];
        end

        // Widen every element into its output lane.
        for (genvar i = 0; i < DATA_COUNT; i++) begin : g_lane
            logic [ELEM_WIDTH-1:0] elem;
            assign elem = assembled[i*ELEM_WIDTH +: ELEM_WIDTH];
            if (OUT_WIDTH == ELEM_WIDTH) begin : g_copy
                assign lanes[i*OUT_WIDTH +: OUT_WIDTH] = elem;
            end else begin : g_ext
                logic fill;
                assign fill = (SIGN_EXT != 0) && elem[ELEM_WIDTH-1];
                assign lanes[i*OUT_WIDTH +: OUT_WIDTH] =
                    {{(OUT_WIDTH-ELEM_WIDTH){fill}}, elem};
            end
        end
    endgenerate

    // Beat counter: wraps on the final beat; an early in_last drops the partial group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (accept) begin
            if (beat_cnt == LAST_BEAT || in_last) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Output register: load on final beat (even while the old group drains), clear on consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            err_last  <= 1'b0;
        end else begin
            err_last <= early_last;
            if (final_beat) begin
                out_data  <= lanes;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_expander.sv
// Directed bench for data_expander: two instances (zero- and sign-extending)
// share one stimulus stream. Inputs change on the falling edge and outputs
// are sampled on the falling edge, away from the active rising edge.
module tb_data_expander;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;
    logic         err_last;

    logic         sx_in_ready;
    logic         sx_out_valid;
    logic [511:0] sx_out_data;
    logic         sx_err_last;

    int tests = 0;
    int fails = 0;

    logic [38:0]  elems [8];
    logic [319:0] grp_a;
    logic [319:0] grp_b;

    data_expander dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_last(err_last)
    );

    data_expander #(.SIGN_EXT(1)) dut_sx (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(sx_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(sx_out_valid), .out_ready(out_ready), .out_data(sx_out_data),
        .err_last(sx_err_last)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pack 8 elements of 39 bits into a 320-bit stream (5 beats of 64 bits).
    function automatic logic [319:0] pack_group(input logic [38:0] e [8]);
        logic [319:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p[i*39 +: 39] = e[i];
        return p;
    endfunction

    // One cycle of stimulus: drive at a falling edge, report in_ready, advance to next falling edge.
    task automatic step(input logic v, input logic [63:0] d, input logic l, output logic rdy);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        #1;
        rdy = in_ready;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic rdy;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (err_last !== 1'b0) begin fails++; $display("FAIL reset_err_last got=%b exp=0", err_last); end
        tests++; if (out_data !== 512'd0) begin fails++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        step(1'b0, 64'd0, 1'b0, rdy);
    endtask

    task automatic test_zero_ext();
        logic rdy;
        logic [63:0] exp_lane;
        for (int i = 0; i < 8; i++) elems[i] = 39'h10_0000_0000 + 39'(i);
        grp_a = pack_group(elems);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, grp_a[k*64 +: 64], k == 4, rdy);
            tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL zext_in_ready beat=%0d got=%b exp=1", k, rdy); end
            if (k < 4) begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL zext_early_valid beat=%0d got=%b exp=0", k, out_valid); end
            end
        end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL zext_out_valid got=%b exp=1", out_valid); end
        for (int i = 0; i < 8; i++) begin
            exp_lane = 64'h0000_0010_0000_0000 + 64'(i);
            tests++; if (out_data[i*64 +: 64] !== exp_lane) begin fails++; $display("FAIL zext_lane%0d got=%h exp=%h", i, out_data[i*64 +: 64], exp_lane); end
        end
        step(1'b0, 64'd0, 1'b0, rdy);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL zext_valid_clear got=%b exp=0", out_valid); end
    endtask

    task automatic test_sign_ext();
        logic rdy;
        elems[0] = 39'h40_0000_0000;
        for (int i = 1; i < 8; i++) elems[i] = 39'h3F_FFFF_FFFF;
        grp_a = pack_group(elems);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step(1'b1, grp_a[k*64 +: 64], k == 4, rdy);
        tests++; if (sx_out_valid !== 1'b1) begin fails++; $display("FAIL sext_out_valid got=%b exp=1", sx_out_valid); end
        tests++; if (sx_out_data[63:0] !== 64'hFFFF_FFC0_0000_0000) begin fails++; $display("FAIL sext_lane0 got=%h exp=ffffffc000000000", sx_out_data[63:0]); end
        for (int i = 1; i < 8; i++) begin
            tests++; if (sx_out_data[i*64 +: 64] !== 64'h0000_003F_FFFF_FFFF) begin fails++; $display("FAIL sext_lane%0d got=%h exp=0000003fffffffff", i, sx_out_data[i*64 +: 64]); end
        end
        tests++; if (out_data[63:0] !== 64'h0000_0040_0000_0000) begin fails++; $display("FAIL sext_zext_lane0 got=%h exp=0000004000000000", out_data[63:0]); end
        step(1'b0, 64'd0, 1'b0, rdy);
    endtask

    task automatic test_back_to_back();
        logic rdy;
        logic exp_valid;
        logic [63:0] exp_lane;
        for (int i = 0; i < 8; i++) elems[i] = 39'h00_1234_5600 + 39'(i);
        grp_a = pack_group(elems);
        for (int i = 0; i < 8; i++) elems[i] = 39'h7F_0000_0000 + 39'(i);
        grp_b = pack_group(elems);
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (n < 5) step(1'b1, grp_a[n*64 +: 64], n == 4, rdy);
            else step(1'b1, grp_b[(n-5)*64 +: 64], n == 9, rdy);
            tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL b2b_in_ready beat=%0d got=%b exp=1", n, rdy); end
            exp_valid = (n == 4) || (n == 9);
            tests++; if (out_valid !== exp_valid) begin fails++; $display("FAIL b2b_out_valid beat=%0d got=%b exp=%b", n, out_valid, exp_valid); end
            if (n == 4 || n == 9) begin
                for (int i = 0; i < 8; i++) begin
                    exp_lane = (n == 4) ? 64'h0000_0000_1234_5600 + 64'(i) : 64'h0000_007F_0000_0000 + 64'(i);
                    tests++; if (out_data[i*64 +: 64] !== exp_lane) begin fails++; $display("FAIL b2b_lane%0d beat=%0d got=%h exp=%h", i, n, out_data[i*64 +: 64], exp_lane); end
                end
            end
        end
        step(1'b0, 64'd0, 1'b0, rdy);
    endtask

    task automatic test_backpressure();
        logic rdy;
        logic [63:0] exp_lane;
        for (int i = 0; i < 8; i++) elems[i] = 39'h01_0101_0100 + 39'(i);
        grp_a = pack_group(elems);
        for (int i = 0; i < 8; i++) elems[i] = 39'h02_0000_0000 + 39'(i);
        grp_b = pack_group(elems);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) step(1'b1, grp_a[k*64 +: 64], k == 4, rdy);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_first_valid got=%b exp=1", out_valid); end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, grp_b[k*64 +: 64], 1'b0, rdy);
            tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL bp_nonfinal_ready beat=%0d got=%b exp=1", k, rdy); end
            tests++; if (out_data[63:0] !== 64'h0000_0001_0101_0100) begin fails++; $display("FAIL bp_hold_lane0 beat=%0d got=%h exp=0000000101010100", k, out_data[63:0]); end
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b1, grp_b[4*64 +: 64], 1'b1, rdy);
            tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL bp_final_stall cyc=%0d got=%b exp=0", c, rdy); end
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_stall_valid cyc=%0d got=%b exp=1", c, out_valid); end
            tests++; if (out_data[7*64 +: 64] !== 64'h0000_0001_0101_0107) begin fails++; $display("FAIL bp_hold_lane7 cyc=%0d got=%h exp=0000000101010107", c, out_data[7*64 +: 64]); end
        end
        out_ready = 1'b1;
        step(1'b1, grp_b[4*64 +: 64], 1'b1, rdy);
        tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b exp=1", rdy); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_second_valid got=%b exp=1", out_valid); end
        for (int i = 0; i < 8; i++) begin
            exp_lane = 64'h0000_0002_0000_0000 + 64'(i);
            tests++; if (out_data[i*64 +: 64] !== exp_lane) begin fails++; $display("FAIL bp_lane%0d got=%h exp=%h", i, out_data[i*64 +: 64], exp_lane); end
        end
        step(1'b0, 64'd0, 1'b0, rdy);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_clear got=%b exp=0", out_valid); end
    endtask

    task automatic test_early_last();
        logic rdy;
        logic [63:0] exp_lane;
        for (int i = 0; i < 8; i++) elems[i] = 39'h7F_FFFF_FFFF;
        grp_a = pack_group(elems);
        for (int i = 0; i < 8; i++) elems[i] = 39'h00_0000_0A00 + 39'(i);
        grp_b = pack_group(elems);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, grp_a[k*64 +: 64], k == 2, rdy);
        tests++; if (err_last !== 1'b1) begin fails++; $display("FAIL early_err_pulse got=%b exp=1", err_last); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL early_no_valid got=%b exp=0", out_valid); end
        step(1'b0, 64'd0, 1'b0, rdy);
        tests++; if (err_last !== 1'b0) begin fails++; $display("FAIL early_err_one_cycle got=%b exp=0", err_last); end
        for (int k = 0; k < 5; k++) begin
            step(1'b1, grp_b[k*64 +: 64], k == 4, rdy);
            if (k < 4) begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL early_regroup_valid beat=%0d got=%b exp=0", k, out_valid); end
            end
        end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL early_regroup_done got=%b exp=1", out_valid); end
        for (int i = 0; i < 8; i++) begin
            exp_lane = 64'h0000_0000_0000_0A00 + 64'(i);
            tests++; if (out_data[i*64 +: 64] !== exp_lane) begin fails++; $display("FAIL early_lane%0d got=%h exp=%h", i, out_data[i*64 +: 64], exp_lane); end
        end
        step(1'b0, 64'd0, 1'b0, rdy);
    endtask

    task automatic test_reset_mid_group();
        logic rdy;
        logic [63:0] exp_lane;
        for (int i = 0; i < 8; i++) elems[i] = 39'h33_3333_3333;
        grp_a = pack_group(elems);
        for (int i = 0; i < 8; i++) elems[i] = 39'h05_0000_0050 + 39'(i);
        grp_b = pack_group(elems);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) step(1'b1, grp_a[k*64 +: 64], k == 4, rdy);
        for (int k = 0; k < 2; k++) step(1'b1, grp_b[k*64 +: 64], 1'b0, rdy);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        tests++; if (out_data !== 512'd0) begin fails++; $display("FAIL rstmid_out_data got=%h exp=0", out_data); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step(1'b1, grp_b[k*64 +: 64], k == 4, rdy);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_group_valid got=%b exp=1", out_valid); end
        for (int i = 0; i < 8; i++) begin
            exp_lane = 64'h0000_0005_0000_0050 + 64'(i);
            tests++; if (out_data[i*64 +: 64] !== exp_lane) begin fails++; $display("FAIL rstmid_lane%0d got=%h exp=%h", i, out_data[i*64 +: 64], exp_lane); end
        end
        step(1'b0, 64'd0, 1'b0, rdy);
    endtask

    // Sequence of scenarios and final report
    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_zero_ext();
        test_sign_ext();
        test_back_to_back();
        test_backpressure();
        test_early_last();
        test_reset_mid_group();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_expander.md
DATA_EXPANDER -- requirements
Module: data_expander

Interface
REQ-001 Parameter BUS_WIDTH, default 64: input beat width in bits.
REQ-002 Parameter ELEM_WIDTH, default 39: packed element width in bits.
REQ-003 Parameter OUT_WIDTH, default 64: restored lane width in bits; ELEM_WIDTH <= OUT_WIDTH.
REQ-004 Parameter DATA_COUNT, default 8: elements per group.
REQ-005 Parameter SIGN_EXT, default 0: 0 zero-extends each element, 1 sign-extends it.
REQ-006 Port clk, input, 1: single clock; all logic rising-edge.
REQ-007 Port rst, input, 1: reset, asynchronous assert, active-high.
REQ-008 Port in_valid, input, 1: input beat valid.
REQ-009 Port in_ready, output, 1: input beat accepted when in_valid && in_ready.
REQ-010 Port in_data, input, BUS_WIDTH: packed beat.
REQ-011 Port in_last, input, 1: marks final beat of a group.
REQ-012 Port out_valid, output, 1: group valid.
REQ-013 Port out_ready, input, 1: group consumed when out_valid && out_ready.
REQ-014 Port out_data, output, DATA_COUNT*OUT_WIDTH: restored lanes, lane i at bits [i*OUT_WIDTH +: OUT_WIDTH].
REQ-015 Port err_last, output, 1: one-cycle pulse on early in_last.

Function
REQ-016 BEATS = ceil(DATA_COUNT*ELEM_WIDTH / BUS_WIDTH), 5 at defaults; each group starts on a beat boundary.
REQ-017 Assembly buffer of BEATS*BUS_WIDTH bits; accepted beat k written to bits [k*BUS_WIDTH +: BUS_WIDTH]; beat_cnt counts 0..BEATS-1.
REQ-018 Element i = buffer[i*ELEM_WIDTH +: ELEM_WIDTH]; bits above DATA_COUNT*ELEM_WIDTH in the final beat are ignored.
REQ-019 Lane i = element i padded to OUT_WIDTH with zeros (SIGN_EXT=0) or copies of element bit ELEM_WIDTH-1 (SIGN_EXT=1); ELEM_WIDTH == OUT_WIDTH is a plain copy.
REQ-020 Output register separate from assembly buffer; accepting final beat (beat_cnt==BEATS-1) loads out_data, sets out_valid on next edge, resets beat_cnt to 0.
REQ-021 Latency: out_valid high the cycle after the final beat handshake.
REQ-022 in_ready = 0 only when beat_cnt==BEATS-1 && out_valid && !out_ready; otherwise 1 (non-final beats always accepted).
REQ-023 Final beat accepted in the same cycle the previous group is consumed: out_data replaced, out_valid stays 1; full throughput of one group per BEATS cycles.
REQ-024 out_valid clears on out_ready when no new group loads that cycle; out_data and out_valid stable while out_valid && !out_ready.
REQ-025 in_last on final beat or absent: no effect; grouping is by beat_cnt alone.
REQ-026 in_last accepted with beat_cnt < BEATS-1: partial group discarded, beat_cnt to 0, err_last high one cycle, output register untouched.
REQ-027 in_valid low: no state change in assembly path; no bubble requirement on input.

Reset
REQ-028 While rst high: out_valid=0, err_last=0, beat_cnt=0, out_data=0, in_ready=1 (combinational from cleared state).
REQ-029 rst mid-group discards collected beats; first beat after release is beat 0.
REQ-030 Buffer contents need no reset; only control and out_data.

Verification
REQ-031 Defaults, SIGN_EXT=0, elements i=0..7 = 0x10_0000_0000+i packed over 5 beats, out_ready=1 -> out_valid 1 cycle after beat 5; lane i = 0x0000_0010_0000_0000+i.
REQ-032 SIGN_EXT=1, element 0 = 0x40_0000_0000, others 0x3F_FFFF_FFFF -> lane0 = 0xFFFF_FFC0_0000_0000, others 0x0000_003F_FFFF_FFFF.
REQ-033 Back-to-back two groups, in_valid=1 continuous, out_ready=1 -> in_ready never 0; out_valid high on cycles 6 and 11.
REQ-034 out_ready=0 with group pending, next group sent -> beats 1-4 accepted, in_ready=0 on beat 5 until out_ready=1, then accepted same cycle; first group's out_data unchanged until consumed.
REQ-035 in_last on beat 3 -> err_last pulse one cycle, no out_valid; next 5 beats form a correct group.
REQ-036 rst pulse after beat 2 -> out_valid=0; following 5 beats produce correct group.
